// File: rtl/messbauer_camac_accumulator.sv
// CAMAC-controlled 4096 x 24 spectrum accumulator for a Mossbauer spectrometer.
// Modes: host program exchange (PROG), velocity-sweep accumulation (MOSS), amplitude analysis (AMPL).
module messbauer_camac_accumulator #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chanel,
  input  logic              start,
  input  logic              count,
  input  logic [4:0]        f,
  input  logic              s1,
  input  logic [DATA_W-1:0] write,
  output logic [DATA_W-1:0] read,
  output logic              x,
  output logic              q,
  output logic [ADDR_W-1:0] address,
  output logic              trig
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {ModeProg, ModeMoss, ModeAmpl} mode_e;

  mode_e             mode_q, mode_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] read_q, read_d;
  logic              x_q, x_d, q_q, q_d, trig_q, trig_d;
  logic              clr_q, clr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]        in_q, in_qq;
  logic [4:0]        f_q, f_qq;

  logic [DATA_W-1:0] mem [Depth];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, inc_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rd, inc_val;
  logic              ev_start, ev_chanel, ev_count, ev_s1;
  logic              f11_entry, f26_entry, camac_hit;

  // Inputs packed as {s1, count, chanel, start}; an event is a registered rising edge.
  assign ev_start  = in_q[0] & ~in_qq[0];
  assign ev_chanel = in_q[1] & ~in_qq[1];
  assign ev_count  = in_q[2] & ~in_qq[2];
  assign ev_s1     = in_q[3] & ~in_qq[3];
  assign f11_entry = (f_q == 5'd11) && (f_qq != 5'd11);
  assign f26_entry = (f_q == 5'd26) && (f_qq != 5'd26);

  assign inc_addr = (mode_q == ModeAmpl) ? write[ADDR_W-1:0] : addr_q;
  assign mem_rd   = mem[inc_addr];
  assign inc_val  = (&mem_rd) ? mem_rd : mem_rd + DATA_W'(1);

  always_comb begin
    mode_d    = mode_q;
    armed_d   = armed_q;
    addr_d    = addr_q;
    clr_d     = clr_q;
    clr_cnt_d = clr_cnt_q;
    trig_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = write;
    camac_hit = 1'b0;
    if (clr_q) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (&clr_cnt_q) clr_d = 1'b0;
    end else begin
      if (ev_s1) begin
        case (f_q)
          5'd9: begin
            clr_d     = 1'b1;
            clr_cnt_d = '0;
            addr_d    = '0;
            armed_d   = 1'b0;
            camac_hit = 1'b1;
          end
          5'd17: begin
            addr_d    = write[ADDR_W-1:0];
            camac_hit = 1'b1;
          end
          5'd16: begin
            mem_we    = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
            camac_hit = 1'b1;
          end
          5'd0: begin
            addr_d    = addr_q + ADDR_W'(1);
            camac_hit = 1'b1;
          end
          default: ;
        endcase
      end

      if (f11_entry) begin
        if (mode_q != ModeProg) begin
          mode_d  = ModeProg;
          armed_d = 1'b0;
        end else begin
          mode_d = ModeAmpl;
        end
      end else if (f26_entry && mode_q == ModeProg) begin
        mode_d = ModeMoss;
      end

      // Host address commands win; a colliding front-end event is dropped.
      if (!camac_hit) begin
        case (mode_q)
          ModeMoss: begin
            if (ev_start) begin
              addr_d  = '0;
              armed_d = 1'b1;
              trig_d  = 1'b1;
            end else if (armed_q) begin
              if (ev_count) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = inc_val;
              end
              if (ev_chanel) begin
                addr_d = addr_q + ADDR_W'(1);
                if (&addr_q) trig_d = 1'b1;
              end
            end
          end
          ModeAmpl: begin
            if (ev_start) begin
              armed_d = 1'b1;
              trig_d  = 1'b1;
            end else if (armed_q && ev_count) begin
              addr_d    = write[ADDR_W-1:0];
              mem_we    = 1'b1;
              mem_waddr = write[ADDR_W-1:0];
              mem_wdata = inc_val;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    x_d    = 1'b0;
    q_d    = 1'b0;
    read_d = (f == 5'd0) ? mem[addr_q] : '0;
    case (f)
      5'd0, 5'd9, 5'd11, 5'd16, 5'd17, 5'd26: begin
        x_d = 1'b1;
        q_d = 1'b1;
      end
      5'd27: begin
        x_d = 1'b1;
        q_d = (mode_q != ModeProg) && armed_q;
      end
      default: ;
    endcase
    // A running clear forces x high and holds q low until the last word is written.
    if (clr_d) begin
      x_d = 1'b1;
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= ModeProg;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      read_q    <= '0;
      x_q       <= 1'b0;
      q_q       <= 1'b0;
      trig_q    <= 1'b0;
      clr_q     <= 1'b0;
      clr_cnt_q <= '0;
      in_q      <= '0;
      in_qq     <= '0;
      f_q       <= '0;
      f_qq      <= '0;
    end else begin
      mode_q    <= mode_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      x_q       <= x_d;
      q_q       <= q_d;
      trig_q    <= trig_d;
      clr_q     <= clr_d;
      clr_cnt_q <= clr_cnt_d;
      in_q      <= {s1, count, chanel, start};
      in_qq     <= in_q;
      f_q       <= f;
      f_qq      <= f_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign read    = read_q;
  assign x       = x_q;
  assign q       = q_q;
  assign address = addr_q;
  assign trig    = trig_q;

endmodule

// File: tb/tb_messbauer_camac_accumulator.sv
// Scenario bench for the Mossbauer CAMAC accumulator; memory reads are checked
// against a bench-side histogram model through an expected-value queue.
module tb_messbauer_camac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        chanel, start, count, s1;
  logic [4:0]  f;
  logic [23:0] write;
  logic [23:0] read;
  logic        x, q, trig;
  logic [11:0] address;

  int total = 0;
  int bad   = 0;

  logic [23:0] model_mem [4096];
  logic [23:0] exp_q [$];
  logic [11:0] exp_addr;

  messbauer_camac_accumulator dut (
    .clk     (clk),
    .rst     (rst),
    .chanel  (chanel),
    .start   (start),
    .count   (count),
    .f       (f),
    .s1      (s1),
    .write   (write),
    .read    (read),
    .x       (x),
    .q       (q),
    .address (address),
    .trig    (trig)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

  // CAMAC command with S1 strobe; keeps the bench address/memory model in step.
  task automatic cmd(input logic [4:0] code, input logic [23:0] data);
    f = code;
    write = data;
    tick(3);
    s1 = 1'b1;
    tick(3);
    s1 = 1'b0;
    tick(3);
    f = 5'd31;
    tick(3);
    case (code)
      5'd17: exp_addr = data[11:0];
      5'd16: begin
        model_mem[exp_addr] = data;
        exp_addr = exp_addr + 12'd1;
      end
      5'd0: exp_addr = exp_addr + 12'd1;
      default: ;
    endcase
  endtask

  task automatic enter_code(input logic [4:0] code);
    f = code;
    tick(3);
    f = 5'd31;
    tick(3);
  endtask

  // which: 0 start, 1 chanel, 2 count, 3 count+chanel together
  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: chanel = 1'b1;
      2: count = 1'b1;
      default: begin
        count = 1'b1;
        chanel = 1'b1;
      end
    endcase
    tick(3);
    start = 1'b0;
    chanel = 1'b0;
    count = 1'b0;
    tick(3);
  endtask

  // Point at addr, select F0 and queue the expected word; caller pops and compares.
  task automatic issue_read(input logic [11:0] a);
    cmd(5'd17, {12'd0, a});
    f = 5'd0;
    exp_q.push_back(model_mem[a]);
    tick(3);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    total++;
    if (address !== 12'd0 || read !== 24'd0 || x !== 1'b0 || q !== 1'b0 || trig !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%0h read=%0h x=%b q=%b trig=%b want all zero",
               address, read, x, q, trig);
    end
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_clear;
    f = 5'd9;
    tick(3);
    s1 = 1'b1;
    tick(3);
    total++;
    if (x !== 1'b1 || q !== 1'b0) begin
      bad++;
      $display("FAIL clear_busy: got x=%b q=%b want x=1 q=0", x, q);
    end
    s1 = 1'b0;
    tick(4100);
    total++;
    if (x !== 1'b1 || q !== 1'b1) begin
      bad++;
      $display("FAIL clear_done: got x=%b q=%b want x=1 q=1", x, q);
    end
    f = 5'd31;
    tick(3);
    for (int i = 0; i < 4096; i++) model_mem[i] = 24'd0;
    exp_addr = 12'd0;
    total++;
    if (address !== 12'd0) begin
      bad++;
      $display("FAIL clear_addr: got %0h want 0", address);
    end
  endtask

  task automatic test_prog_ignore;
    logic [23:0] e;
    pulse(0);
    pulse(1);
    pulse(2);
    total++;
    if (address !== 12'd0) begin
      bad++;
      $display("FAIL prog_ignore_addr: got %0h want 0", address);
    end
    f = 5'd27;
    tick(3);
    total++;
    if (q !== 1'b0 || x !== 1'b1) begin
      bad++;
      $display("FAIL prog_f27: got x=%b q=%b want x=1 q=0", x, q);
    end
    issue_read(12'd0);
    e = exp_q.pop_front();
    total++;
    if (read !== e) begin
      bad++;
      $display("FAIL prog_mem0: got %0h want %0h", read, e);
    end
    f = 5'd31;
  endtask

  task automatic test_camac;
    logic [23:0] e;
    cmd(5'd17, 24'd5);
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL f17_addr: got %0h want %0h", address, exp_addr);
    end
    cmd(5'd16, 24'h00ABCD);
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL f16_addr: got %0h want %0h", address, exp_addr);
    end
    issue_read(12'd5);
    e = exp_q.pop_front();
    total++;
    if (read !== e || q !== 1'b1 || x !== 1'b1) begin
      bad++;
      $display("FAIL f0_read: got read=%0h x=%b q=%b want read=%0h x=1 q=1", read, x, q, e);
    end
    cmd(5'd0, 24'd0);
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL f0_advance: got %0h want %0h", address, exp_addr);
    end
  endtask

  task automatic test_moss;
    int n;
    logic [23:0] e;
    enter_code(5'd26);
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (trig === 1'b1) n++;
      if (i == 2) start = 1'b0;
    end
    tick(3);
    exp_addr = 12'd0;
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL moss_start_trig: got %0d trig cycles want 1", n);
    end
    for (int k = 0; k < 2; k++) begin
      pulse(2);
      pulse(2);
      model_mem[exp_addr] = sat_inc(sat_inc(model_mem[exp_addr]));
      pulse(1);
      exp_addr = exp_addr + 12'd1;
    end
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL moss_addr: got %0h want %0h", address, exp_addr);
    end
    f = 5'd27;
    tick(3);
    total++;
    if (q !== 1'b1) begin
      bad++;
      $display("FAIL moss_f27: got q=%b want 1", q);
    end
    for (int a = 0; a < 2; a++) begin
      issue_read(12'(a));
      e = exp_q.pop_front();
      total++;
      if (read !== e) begin
        bad++;
        $display("FAIL moss_mem%0d: got %0h want %0h", a, read, e);
      end
    end
    f = 5'd31;
  endtask

  task automatic test_ampl;
    logic [23:0] e;
    enter_code(5'd11);
    f = 5'd27;
    tick(3);
    total++;
    if (q !== 1'b0) begin
      bad++;
      $display("FAIL ampl_back_to_prog_f27: got q=%b want 0", q);
    end
    enter_code(5'd11);
    pulse(0);
    write = 24'd7;
    tick(2);
    pulse(2);
    pulse(2);
    model_mem[7] = sat_inc(sat_inc(model_mem[7]));
    exp_addr = 12'd7;
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL ampl_addr: got %0h want %0h", address, exp_addr);
    end
    issue_read(12'd7);
    e = exp_q.pop_front();
    total++;
    if (read !== e) begin
      bad++;
      $display("FAIL ampl_mem7: got %0h want %0h", read, e);
    end
    f = 5'd31;
    enter_code(5'd11);
  endtask

  task automatic test_saturate_wrap;
    int n;
    logic [23:0] e;
    cmd(5'd17, 24'd3);
    cmd(5'd16, 24'hFFFFFF);
    enter_code(5'd26);
    pulse(0);
    exp_addr = 12'd0;
    for (int k = 0; k < 3; k++) begin
      pulse(1);
      exp_addr = exp_addr + 12'd1;
    end
    pulse(2);
    model_mem[exp_addr] = sat_inc(model_mem[exp_addr]);
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL sat_addr: got %0h want %0h", address, exp_addr);
    end
    issue_read(12'd3);
    e = exp_q.pop_front();
    total++;
    if (read !== e) begin
      bad++;
      $display("FAIL sat_value: got %0h want %0h", read, e);
    end
    f = 5'd31;
    cmd(5'd17, 24'd4095);
    chanel = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (trig === 1'b1) n++;
      if (i == 2) chanel = 1'b0;
    end
    tick(3);
    total++;
    if (address !== 12'd0 || n != 1) begin
      bad++;
      $display("FAIL wrap: got addr=%0h trig_cycles=%0d want addr=0 trig_cycles=1", address, n);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] e;
    pulse(0);
    exp_addr = 12'd0;
    pulse(3);
    model_mem[0] = sat_inc(model_mem[0]);
    exp_addr = 12'd1;
    pulse(1);
    exp_addr = 12'd2;
    pulse(2);
    model_mem[2] = sat_inc(model_mem[2]);
    total++;
    if (address !== exp_addr) begin
      bad++;
      $display("FAIL simul_addr: got %0h want %0h", address, exp_addr);
    end
    f = 5'd0;
    tick(3);
    #2 rst = 1'b0;
    #1;
    total++;
    if (address !== 12'd0 || read !== 24'd0 || x !== 1'b0 || q !== 1'b0 || trig !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got addr=%0h read=%0h x=%b q=%b trig=%b want all zero",
               address, read, x, q, trig);
    end
    tick(2);
    rst = 1'b1;
    f = 5'd31;
    tick(3);
    f = 5'd27;
    tick(3);
    total++;
    if (q !== 1'b0) begin
      bad++;
      $display("FAIL reset_mode_prog: got q=%b want 0", q);
    end
    f = 5'd31;
    pulse(2);
    for (int a = 0; a < 3; a += 2) begin
      issue_read(12'(a));
      e = exp_q.pop_front();
      total++;
      if (read !== e) begin
        bad++;
        $display("FAIL kept_mem%0d: got %0h want %0h", a, read, e);
      end
    end
    f = 5'd31;
  endtask

  initial begin
    chanel = 1'b0;
    start = 1'b0;
    count = 1'b0;
    s1 = 1'b0;
    f = 5'd31;
    write = 24'd0;
    exp_addr = 12'd0;
    test_reset();
    test_clear();
    test_prog_ignore();
    test_camac();
    test_moss();
    test_ampl();
    test_saturate_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
